// File: rtl/apb_slave_mem.sv
// APB3 completer backed by a small register file.
//
// Parameters:
//   DEPTH       number of 32-bit registers (power of two, 2..256)
//   WAIT_CYCLES wait states inserted in every access phase (0..15)
//   BASE_ADDR   byte address of register 0 (DEPTH*4 aligned)
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   psel     APB select
//   penable  APB access-phase strobe
//   pwrite   1 = write, 0 = read
//   paddr    byte address
//   pwdata   write data
//   prdata   read data, nonzero only on a completing valid read
//   pready   transfer completion (combinational)
//   pslverr  transfer error, only while pready = 1
module apb_slave_mem #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr
);

    localparam int unsigned IDX_W     = $clog2(DEPTH);
    localparam logic [3:0]  WAIT_LAST = 4'(WAIT_CYCLES);
    localparam logic [31:0] SPAN      = 32'(DEPTH * 4);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [31:0]        mem_q [DEPTH];
    logic [31:0]        mem_d [DEPTH];

    logic [31:0]        off;
    logic [IDX_W-1:0]   idx;
    logic               valid;
    logic               done;

    // Address decode relative to the window base (wrapping subtraction).
    always_comb begin
        off   = paddr - BASE_ADDR;
        idx   = off[IDX_W+1:2];
        valid = (off[1:0] == 2'b00) && (off < SPAN);
    end

    // Completion and response; reset forces every output low.
    always_comb begin
        done    = !rst && (state_q == ACCESS) && psel && penable && (cnt_q == WAIT_LAST);
        pready  = done;
        pslverr = done && !valid;
        prdata  = (done && valid && !pwrite) ? mem_q[idx] : 32'h0;
    end

    // Next-state, wait counter and register-file update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mem_d   = mem_q;
        case (state_q)
            IDLE: begin
                // penable without a setup phase is ignored here
                if (psel && !penable) begin
                    state_d = ACCESS;
                    cnt_d   = 4'd0;
                end
            end
            ACCESS: begin
                if (!psel) begin
                    state_d = IDLE;             // abort
                end else if (!penable) begin
                    cnt_d   = 4'd0;             // fresh setup: restart the access
                end else if (cnt_q == WAIT_LAST) begin
                    state_d = IDLE;             // completes on this edge
                end else begin
                    cnt_d   = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
        if (done && valid && pwrite) begin
            mem_d[idx] = pwdata;
        end
    end

    // State, counter and register file.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'h0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mem_q   <= mem_d;
        end
    end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: three instances (0, 3 and 2 wait
// states) share the APB bus except for their individual psel lines.
module tb_apb_slave_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  psel_v;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata_v  [3];
    logic        pready_v  [3];
    logic        pslverr_v [3];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0] model [3][16];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    apb_slave_mem #(.DEPTH(16), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u_w0 (
        .clk(clk), .rst(rst), .psel(psel_v[0]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[0]), .pready(pready_v[0]),
        .pslverr(pslverr_v[0])
    );

    apb_slave_mem #(.DEPTH(16), .WAIT_CYCLES(3), .BASE_ADDR(32'h0)) u_w3 (
        .clk(clk), .rst(rst), .psel(psel_v[1]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[1]), .pready(pready_v[1]),
        .pslverr(pslverr_v[1])
    );

    apb_slave_mem #(.DEPTH(16), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) u_w2 (
        .clk(clk), .rst(rst), .psel(psel_v[2]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[2]), .pready(pready_v[2]),
        .pslverr(pslverr_v[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, want);
        end
    endtask

    function automatic int wait_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 3 : 2);
    endfunction

    // One APB transfer to instance d; starts and ends just after a rising edge.
    task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic err, output int waits);
        bit ok;
        ok    = 1'b0;
        waits = 0;
        rdata = 32'h0;
        err   = 1'b0;
        psel_v  = 3'(1 << d);
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = wdata;
        @(posedge clk); #1;
        penable = 1'b1;
        for (int k = 0; k < 32 && !ok; k++) begin
            @(negedge clk);
            if (pready_v[d]) begin
                ok    = 1'b1;
                rdata = prdata_v[d];
                err   = pslverr_v[d];
            end else begin
                waits++;
                check("wait_pslverr", 32'(pslverr_v[d]), 32'h0);
                check("wait_prdata", prdata_v[d], 32'h0);
            end
            @(posedge clk); #1;
        end
        if (!ok) check("pready_timeout", 32'h0, 32'h1);
        psel_v  = 3'b000;
        penable = 1'b0;
    endtask

    task automatic do_write(input int d, input logic [31:0] addr, input logic [31:0] data,
                            input logic exp_err, input string tag);
        logic [31:0] rd;
        logic        er;
        int          w;
        xfer(d, 1'b1, addr, data, rd, er, w);
        check({tag, "_err"}, 32'(er), 32'(exp_err));
        check({tag, "_waits"}, 32'(w), 32'(wait_of(d)));
    endtask

    task automatic do_read(input int d, input logic [31:0] addr, input logic [31:0] exp_data,
                           input logic exp_err, input string tag);
        logic [31:0] rd;
        logic        er;
        int          w;
        xfer(d, 1'b0, addr, 32'h0, rd, er, w);
        check({tag, "_data"}, rd, exp_data);
        check({tag, "_err"}, 32'(er), 32'(exp_err));
        check({tag, "_waits"}, 32'(w), 32'(wait_of(d)));
    endtask

    task automatic readback(input int d, input string tag);
        for (int i = 0; i < 16; i++) begin
            do_read(d, 32'(i * 4), model[d][i], 1'b0, $sformatf("%s_r%0d", tag, i));
        end
    endtask

    task automatic check_quiet(input string tag);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("%s_pready%0d", tag, d), 32'(pready_v[d]), 32'h0);
            check($sformatf("%s_pslverr%0d", tag, d), 32'(pslverr_v[d]), 32'h0);
            check($sformatf("%s_prdata%0d", tag, d), prdata_v[d], 32'h0);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 16; i++) model[d][i] = 32'h0;
        end
        rst     = 1'b1;
        psel_v  = 3'b000;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 32'h0;
        pwdata  = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        psel_v  = 3'b111;
        penable = 1'b1;
        pwrite  = 1'b0;
        @(negedge clk);
        check_quiet("reset");
        @(posedge clk); #1;
        rst     = 1'b0;
        psel_v  = 3'b000;
        penable = 1'b0;
        @(posedge clk); #1;

        // penable without setup is ignored
        psel_v  = 3'b001;
        penable = 1'b1;
        pwrite  = 1'b0;
        paddr   = 32'h8;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("nosetup_pready", 32'(pready_v[0]), 32'h0);
            @(posedge clk); #1;
        end
        psel_v  = 3'b000;
        penable = 1'b0;
        @(posedge clk); #1;

        // zero-wait write then read
        do_write(0, 32'h08, 32'hDEAD_BEEF, 1'b0, "w0_wr08");
        model[0][2] = 32'hDEAD_BEEF;
        do_read(0, 32'h08, 32'hDEAD_BEEF, 1'b0, "w0_rd08");

        // write immediately followed by read of the same address
        do_write(0, 32'h10, 32'h1234_5678, 1'b0, "w0_wr10");
        model[0][4] = 32'h1234_5678;
        do_read(0, 32'h10, 32'h1234_5678, 1'b0, "w0_rd10");

        // out-of-range and misaligned accesses
        do_write(0, 32'h40, 32'hBAD0_0040, 1'b1, "w0_wr40");
        do_write(0, 32'h05, 32'hBAD0_0005, 1'b1, "w0_wr05");
        do_read(0, 32'h48, 32'h0, 1'b1, "w0_rd48");
        do_read(0, 32'h0A, 32'h0, 1'b1, "w0_rd0a");
        readback(0, "w0_inv");

        // back-to-back writes, each 2 cycles with no idle gap
        t0 = cyc;
        do_write(0, 32'h00, 32'hAAAA_0000, 1'b0, "b2b_00");
        do_write(0, 32'h04, 32'hAAAA_0004, 1'b0, "b2b_04");
        do_write(0, 32'h3C, 32'hAAAA_003C, 1'b0, "b2b_3c");
        check("b2b_cycles", 32'(cyc - t0), 32'd6);
        model[0][0]  = 32'hAAAA_0000;
        model[0][1]  = 32'hAAAA_0004;
        model[0][15] = 32'hAAAA_003C;
        readback(0, "w0_b2b");

        // three wait states: read 0x04 after reset
        do_read(1, 32'h04, 32'h0, 1'b0, "w3_rd04");

        // abort: psel dropped in the second wait cycle of a write to 0x0C
        psel_v  = 3'b010;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'h0C;
        pwdata  = 32'hCAFE_F00D;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        check("abort_wait1", 32'(pready_v[1]), 32'h0);
        @(posedge clk); #1;
        psel_v  = 3'b000;
        penable = 1'b0;
        @(negedge clk);
        check("abort_wait2", 32'(pready_v[1]), 32'h0);
        @(posedge clk); #1;
        do_read(1, 32'h0C, 32'h0, 1'b0, "w3_abort_rd0c");
        do_write(1, 32'h0C, 32'h5A5A_0003, 1'b0, "w3_wr0c");
        do_read(1, 32'h0C, 32'h5A5A_0003, 1'b0, "w3_rd0c");

        // reset in the middle of a two-wait write
        do_write(2, 32'h00, 32'h1111_1111, 1'b0, "w2_wr00");
        do_write(2, 32'h3C, 32'h2222_2222, 1'b0, "w2_wr3c");
        do_read(2, 32'h00, 32'h1111_1111, 1'b0, "w2_rd00");
        psel_v  = 3'b100;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'h08;
        pwdata  = 32'h3333_3333;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_quiet("midrst");
        @(posedge clk); #1;
        rst     = 1'b0;
        psel_v  = 3'b000;
        penable = 1'b0;
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 16; i++) model[d][i] = 32'h0;
        end
        @(posedge clk); #1;
        readback(2, "w2_rst");
        readback(0, "w0_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
